sum_block_averager: RTL and testbench

- Downstream consumer of the 2-cycle, 4-input pipelined adder.
- Takes each 16-bit sum with a qualifying valid, accumulates blocks of 2^LOG2_N sums, and emits the block total and truncated average through a valid/ready output register.
- The upstream adder cannot stall, so input is never back-pressured. Results not taken in time are overwritten and flagged.

---
 rtl/sum_block_averager.sv | 114 +++++++++++
 tb/tb_sum_block_averager.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sum_block_averager.sv
// sum_block_averager
// Accumulates blocks of 2**LOG2_N unsigned sums from the upstream adder and
// presents each block total plus its truncated average in an output register.
//
// Handshake: a result is transferred on any edge where out_valid=1 and
// out_ready=1. out_valid never depends combinationally on out_ready. The
// input side has no ready because the adder cannot stall. A result that is
// replaced while out_valid=1 and out_ready=0 sets the sticky overrun flag.
// out_valid is the output state register (FULL), so it doubles as the
// visible FSM state.
module sum_block_averager #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     clear,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W+LOG2_N-1:0] out_sum,
    output logic [DATA_W-1:0]        out_avg,
    output logic                     overrun,
    output logic [LOG2_N-1:0]        sample_cnt
);

    localparam int ACC_W = DATA_W + LOG2_N;
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_q;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [LOG2_N-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]    sum_q;
    logic [DATA_W-1:0]   avg_q;
    logic                ovr_q;
    logic [ACC_W-1:0]    total;
    logic                complete;

    // Running total including this cycle's sample, and block-complete detect.
    always_comb begin
        total    = acc_q + ACC_W'(in_data);
        complete = in_valid && (cnt_q == CNT_LAST);
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (complete) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (in_valid) begin
            acc_d = total;
            cnt_d = cnt_q + LOG2_N'(1);
        end
    end

    // Accumulator and sample counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // Output FSM: result register, valid state and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            sum_q   <= '0;
            avg_q   <= '0;
            ovr_q   <= 1'b0;
        end else if (clear) begin
            state_q <= EMPTY;
            sum_q   <= '0;
            avg_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            if (complete) begin
                sum_q <= total;
                avg_q <= total[ACC_W-1:LOG2_N];
            end
            case (state_q)
                EMPTY: begin
                    if (complete) state_q <= FULL;
                end
                FULL: begin
                    if (complete) begin
                        // Replacing an untaken result is an overrun.
                        if (!out_ready) ovr_q <= 1'b1;
                    end else if (out_ready) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign out_valid  = (state_q == FULL);
    assign out_sum    = sum_q;
    assign out_avg    = avg_q;
    assign overrun    = ovr_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_sum_block_averager.sv
// Bench for sum_block_averager: directed scenarios followed by a random
// phase, all checked against a block-list reference model.
module tb_sum_block_averager;

  localparam int DATA_W = 16;
  localparam int LOG2_N = 3;
  localparam int N      = 1 << LOG2_N;
  localparam int ACC_W  = DATA_W + LOG2_N;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              clear = 1'b0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [ACC_W-1:0]  out_sum;
  logic [DATA_W-1:0] out_avg;
  logic              overrun;
  logic [LOG2_N-1:0] sample_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: samples of the open block, and the pending result.
  int unsigned blk[$];
  bit          exp_valid;
  int unsigned exp_sum;
  int unsigned exp_avg;
  bit          exp_ovr;

  // clock / reset
  always #5 clk = ~clk;

  sum_block_averager #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .clear(clear), .out_ready(out_ready), .out_valid(out_valid),
    .out_sum(out_sum), .out_avg(out_avg), .overrun(overrun),
    .sample_cnt(sample_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"},  32'(out_valid),  32'(exp_valid));
    check({tag, ".out_sum"},    32'(out_sum),    exp_sum);
    check({tag, ".out_avg"},    32'(out_avg),    exp_avg);
    check({tag, ".overrun"},    32'(overrun),    32'(exp_ovr));
    check({tag, ".sample_cnt"}, 32'(sample_cnt), blk.size());
  endtask

  task automatic model_reset();
    blk.delete();
    exp_valid = 0;
    exp_sum   = 0;
    exp_avg   = 0;
    exp_ovr   = 0;
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then check.
  task automatic cycle(input bit v, input int unsigned d, input bit rdy, input bit clr,
                       input string tag);
    bit          done;
    int unsigned s;
    in_valid  = v;
    in_data   = DATA_W'(d);
    out_ready = rdy;
    clear     = clr;
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else begin
      done = 0;
      s    = 0;
      if (v) begin
        blk.push_back(d);
        if (blk.size() == N) begin
          foreach (blk[i]) s += blk[i];
          blk.delete();
          done = 1;
        end
      end
      if (done) begin
        if (exp_valid && !rdy) exp_ovr = 1;
        exp_valid = 1;
        exp_sum   = s;
        exp_avg   = s / N;
      end else if (exp_valid && rdy) begin
        exp_valid = 0;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n, input bit rdy, input string tag);
    for (int i = 0; i < n; i++) cycle(0, 0, rdy, 0, tag);
  endtask

  task automatic apply_reset(input string tag);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    clear     = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();

    // Reset state.
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("reset_release");

    // 100..800 with ready high: single-cycle valid pulse, sum 3600 avg 450.
    for (int i = 1; i <= N; i++) cycle(1, 100 * i, 1, 0, "ramp");
    check("ramp.sum_const", 32'(out_sum), 3600);
    check("ramp.avg_const", 32'(out_avg), 450);
    idle(2, 1, "ramp_drain");

    // Adder maximum with random gaps: no overflow.
    for (int i = 0; i < N; i++) begin
      idle($urandom_range(0, 3), 1, "max_gap");
      cycle(1, 65532, 1, 0, "max");
    end
    check("max.sum_const", 32'(out_sum), 524256);
    check("max.avg_const", 32'(out_avg), 65532);
    idle(1, 1, "max_drain");

    // Truncation of the average.
    for (int i = 0; i < N - 1; i++) cycle(1, 1, 1, 0, "trunc");
    cycle(1, 2, 1, 0, "trunc_last");
    check("trunc.avg_const", 32'(out_avg), 1);
    idle(1, 1, "trunc_drain");

    // Two blocks with ready low: overwrite and overrun, then drain and clear.
    for (int i = 0; i < N; i++) cycle(1, 100, 0, 0, "ovr_blk1");
    for (int i = 0; i < N; i++) cycle(1, 200, 0, 0, "ovr_blk2");
    check("ovr.sum_const", 32'(out_sum), 1600);
    check("ovr.flag_const", 32'(overrun), 1);
    idle(2, 0, "ovr_hold");
    idle(1, 1, "ovr_take");
    check("ovr.sticky_const", 32'(overrun), 1);
    cycle(0, 0, 0, 1, "ovr_clear");

    // Accept on the same edge that the next block completes: no overrun.
    for (int i = 0; i < N; i++) cycle(1, 5, 0, 0, "same_blk1");
    for (int i = 0; i < N - 1; i++) cycle(1, 7, 0, 0, "same_blk2");
    cycle(1, 7, 1, 0, "same_edge");
    check("same.valid_const", 32'(out_valid), 1);
    check("same.ovr_const", 32'(overrun), 0);
    idle(1, 1, "same_drain");

    // clear together with in_valid mid-block, then a clean block of 10s.
    for (int i = 0; i < 5; i++) cycle(1, 999, 1, 0, "clr_part");
    cycle(1, 999, 1, 1, "clr_with_valid");
    for (int i = 0; i < N; i++) cycle(1, 10, 1, 0, "clr_blk");
    check("clr.sum_const", 32'(out_sum), 80);
    idle(1, 1, "clr_drain");

    // Reset mid-block, then a clean block of 10s.
    for (int i = 0; i < 3; i++) cycle(1, 555, 1, 0, "rst_part");
    apply_reset("rst_mid");
    for (int i = 0; i < N; i++) cycle(1, 10, 1, 0, "rst_blk");
    check("rst.sum_const", 32'(out_sum), 80);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(bit'($urandom_range(0, 3) != 0), $urandom_range(0, 65535),
            bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 60) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
